// File: rtl/ws_weight_loader_if.sv
// Upstream weight-buffer stream into the weight loader: one tile row per beat.
interface ws_weight_loader_if #(
  parameter int DW = 32
) ();
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;

  // Weight buffer side: offers rows.
  modport master (
    output w_valid,
    output w_data,
    input  w_ready
  );

  // Loader side: accepts rows.
  modport slave (
    input  w_valid,
    input  w_data,
    output w_ready
  );
endinterface

// File: rtl/ws_weight_loader.sv
// Weight-stationary loader: buffers one ROWS x COLS weight tile from the
// upstream stream, then shifts it down the PE columns (last row first) so
// that PE row r ends up holding tile row r. Sole driver of the array mode line.
module ws_weight_loader #(
  parameter int WORDWIDTH = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ws_weight_loader_if.slave         w_if,
  input  logic                      array_busy,
  output logic                      mode_o,
  output logic [COLS*WORDWIDTH-1:0] w_col,
  output logic                      load_done,
  output logic                      weights_loaded
);

  localparam int DW = COLS * WORDWIDTH;
  localparam int CW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARB,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q [ROWS];
  logic [DW-1:0] buf_d [ROWS];

  logic          mode_q, mode_d;
  logic [DW-1:0] w_col_q, w_col_d;
  logic          load_done_q, load_done_d;
  logic          weights_loaded_q, weights_loaded_d;

  logic          w_ready_int;
  logic          accept;

  // State, counter, tile buffer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      for (int unsigned i = 0; i < ROWS; i++) buf_q[i] <= '0;
      mode_q           <= 1'b0;
      w_col_q          <= '0;
      load_done_q      <= 1'b0;
      weights_loaded_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      buf_q            <= buf_d;
      mode_q           <= mode_d;
      w_col_q          <= w_col_d;
      load_done_q      <= load_done_d;
      weights_loaded_q <= weights_loaded_d;
    end
  end

  // Next state: fill rows, wait for an idle array, shift ROWS rows, finish.
  // cnt is the buffer write row while filling and the shift index while shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    accept  = w_if.w_valid && w_ready_int;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          buf_d[0] = w_if.w_data;
          cnt_d    = CW'(1);
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          buf_d[cnt_q] = w_if.w_data;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_ARB;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ARB: begin
        if (!array_busy) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: registered values are derived from the next state so they line
  // up with the state they belong to; w_ready is decoded from the current state.
  always_comb begin
    w_ready_int      = reset_n && ((state_q == S_IDLE) || (state_q == S_FILL));
    mode_d           = (state_d == S_SHIFT);
    w_col_d          = '0;
    if (state_d == S_SHIFT) w_col_d = buf_q[LAST - cnt_d];
    load_done_d      = (state_d == S_DONE);
    weights_loaded_d = weights_loaded_q;
    if (state_d == S_SHIFT)     weights_loaded_d = 1'b0;
    else if (state_d == S_DONE) weights_loaded_d = 1'b1;
  end

  assign w_if.w_ready   = w_ready_int;
  assign mode_o         = mode_q;
  assign w_col          = w_col_q;
  assign load_done      = load_done_q;
  assign weights_loaded = weights_loaded_q;

endmodule

// File: tb/tb_ws_weight_loader.sv
// Directed bench for ws_weight_loader with a 4-deep PE weight chain model per column.
module tb_ws_weight_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        array_busy;
  logic        mode_o;
  logic [31:0] w_col;
  logic        load_done;
  logic        weights_loaded;

  ws_weight_loader_if #(.DW(32)) w_if ();

  ws_weight_loader #(
    .WORDWIDTH(8),
    .ROWS(4),
    .COLS(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .w_if          (w_if),
    .array_busy    (array_busy),
    .mode_o        (mode_o),
    .w_col         (w_col),
    .load_done     (load_done),
    .weights_loaded(weights_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // PE array model and event monitors, sampled at the rising edge.
  logic [7:0]  pe [4][4];
  logic [31:0] wlog [256];
  int cyc = 0, mode_cnt = 0, done_cnt = 0, beat_cnt = 0, log_n = 0;
  int mode_start_cyc = -1, last_acc_cyc = -1, prev_done_cyc = -1, last_done_cyc = -1;
  logic mode_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mode_prev <= mode_o;
    if (reset_n && mode_o) begin
      for (int r = 3; r > 0; r--)
        for (int c = 0; c < 4; c++) pe[r][c] <= pe[r-1][c];
      for (int c = 0; c < 4; c++) pe[0][c] <= w_col[c*8 +: 8];
      mode_cnt <= mode_cnt + 1;
      wlog[log_n % 256] <= w_col;
      log_n <= log_n + 1;
      if (!mode_prev) mode_start_cyc <= cyc;
    end
    if (reset_n && w_if.w_valid && w_if.w_ready) begin
      beat_cnt <= beat_cnt + 1;
      last_acc_cyc <= cyc;
    end
    if (load_done) begin
      done_cnt <= done_cnt + 1;
      prev_done_cyc <= last_done_cyc;
      last_done_cyc <= cyc;
    end
  end

  function automatic logic [31:0] row_word(input int base, input int r);
    logic [31:0] w;
    for (int c = 0; c < 4; c++) w[c*8 +: 8] = 8'(base + 16*r + c);
    return w;
  endfunction

  task automatic send_beat(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    w_if.w_valid = 1'b1;
    w_if.w_data  = d;
    for (int n = 0; n < 100; n++) begin
      if (w_if.w_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_beat: beat %h not accepted within 100 cycles", d);
    end
  endtask

  task automatic send_tile(input int base, input bit gapped);
    for (int r = 0; r < 4; r++) begin
      send_beat(row_word(base, r));
      if (gapped || r == 3) begin
        @(negedge clk);
        w_if.w_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (load_done) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_done_timeout: load_done not seen within 100 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic check_resident(input string name, input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (pe[r][c] !== 8'(base + 16*r + c)) begin
          fails++;
          $display("FAIL %s_pe[%0d][%0d]: got %h expected %h", name, r, c, pe[r][c],
                   8'(base + 16*r + c));
        end
      end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    array_busy = 1'b0;
    w_if.w_valid = 1'b0;
    w_if.w_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({w_if.w_ready, mode_o, w_col, load_done, weights_loaded} !== 36'd0) begin
      fails++;
      $display("FAIL reset_values: ready=%b mode=%b w_col=%h done=%b loaded=%b expected all 0",
               w_if.w_ready, mode_o, w_col, load_done, weights_loaded);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      tests++;
      if ({w_if.w_ready, mode_o, w_col, load_done} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
        fails++;
        $display("FAIL idle_cycle%0d: ready=%b mode=%b w_col=%h done=%b expected 1 0 0 0",
                 n, w_if.w_ready, mode_o, w_col, load_done);
      end
    end
    tests++;
    if (done_cnt !== d0) begin
      fails++;
      $display("FAIL idle_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_basic();
    int m0, d0, b0, l0;
    m0 = mode_cnt; d0 = done_cnt; b0 = beat_cnt; l0 = log_n;
    send_tile(0, 1'b0);
    wait_done("basic");
    tests++;
    if (mode_cnt - m0 !== 4) begin
      fails++;
      $display("FAIL basic_mode_cycles: got %0d expected 4", mode_cnt - m0);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wlog[(l0 + k) % 256] !== row_word(0, 3 - k)) begin
        fails++;
        $display("FAIL basic_w_col_seq%0d: got %h expected %h", k, wlog[(l0 + k) % 256],
                 row_word(0, 3 - k));
      end
    end
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    tests++;
    if (beat_cnt - b0 !== 4) begin
      fails++;
      $display("FAIL basic_beats: got %0d expected 4", beat_cnt - b0);
    end
    tests++;
    if (weights_loaded !== 1'b1) begin
      fails++;
      $display("FAIL basic_loaded: got %b expected 1", weights_loaded);
    end
    check_resident("basic", 0);
  endtask

  task automatic test_gapped();
    int b0;
    b0 = beat_cnt;
    send_tile(0, 1'b1);
    wait_done("gapped");
    tests++;
    if (beat_cnt - b0 !== 4) begin
      fails++;
      $display("FAIL gapped_beats: got %0d expected 4", beat_cnt - b0);
    end
    tests++;
    if (mode_start_cyc !== last_acc_cyc + 2) begin
      fails++;
      $display("FAIL gapped_shift_start: got cycle %0d expected %0d", mode_start_cyc,
               last_acc_cyc + 2);
    end
    check_resident("gapped", 0);
  endtask

  task automatic test_busy();
    int b0, fall_cyc;
    b0 = beat_cnt;
    array_busy = 1'b1;
    for (int r = 0; r < 4; r++) send_beat(row_word(32, r));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      w_if.w_valid = 1'b1;
      w_if.w_data  = 32'hDEAD_BEEF;
      tests++;
      if ({mode_o, w_if.w_ready} !== 2'b00) begin
        fails++;
        $display("FAIL busy_hold%0d: mode=%b ready=%b expected 0 0", n, mode_o, w_if.w_ready);
      end
    end
    @(negedge clk);
    array_busy = 1'b0;
    w_if.w_valid = 1'b0;
    fall_cyc = cyc;
    wait_done("busy");
    tests++;
    if (mode_start_cyc !== fall_cyc + 1) begin
      fails++;
      $display("FAIL busy_shift_start: got cycle %0d expected %0d", mode_start_cyc, fall_cyc + 1);
    end
    tests++;
    if (beat_cnt - b0 !== 4) begin
      fails++;
      $display("FAIL busy_beats: got %0d expected 4", beat_cnt - b0);
    end
    check_resident("busy", 32);
  endtask

  task automatic test_reset_shift();
    int d0;
    bit seen;
    seen = 1'b0;
    send_tile(0, 1'b0);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mode_o) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rst_shift_timeout: mode_o not seen within 50 cycles");
    end
    @(negedge clk);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({mode_o, w_col, weights_loaded, load_done} !== 35'd0) begin
      fails++;
      $display("FAIL rst_shift_outputs: mode=%b w_col=%h loaded=%b done=%b expected all 0",
               mode_o, w_col, weights_loaded, load_done);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt !== d0) begin
      fails++;
      $display("FAIL rst_shift_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
    send_tile(64, 1'b0);
    wait_done("rst_reload");
    tests++;
    if (weights_loaded !== 1'b1) begin
      fails++;
      $display("FAIL rst_reload_loaded: got %b expected 1", weights_loaded);
    end
    check_resident("rst_reload", 64);
  endtask

  task automatic test_back_to_back();
    int d0, b0, phase, win_err;
    d0 = done_cnt; b0 = beat_cnt; phase = 0; win_err = 0;
    fork
      begin
        for (int r = 0; r < 4; r++) send_beat(row_word(0, r));
        for (int r = 0; r < 4; r++) send_beat(row_word(128, r));
        @(negedge clk);
        w_if.w_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 80 && phase != 3; n++) begin
          @(negedge clk);
          case (phase)
            0: if (load_done) begin
                 if (weights_loaded !== 1'b1) win_err++;
                 phase = 1;
               end
            1: if (mode_o) begin
                 if (weights_loaded !== 1'b0) win_err++;
                 phase = 2;
               end else if (weights_loaded !== 1'b1) win_err++;
            2: if (load_done) begin
                 if (weights_loaded !== 1'b1) win_err++;
                 phase = 3;
               end else if (weights_loaded !== 1'b0) win_err++;
            default: ;
          endcase
        end
      end
    join
    @(negedge clk);
    tests++;
    if (phase !== 3) begin
      fails++;
      $display("FAIL b2b_progress: reached phase %0d expected 3", phase);
    end
    tests++;
    if (win_err !== 0) begin
      fails++;
      $display("FAIL b2b_loaded_window: got %0d bad cycles expected 0", win_err);
    end
    tests++;
    if (done_cnt - d0 !== 2) begin
      fails++;
      $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt - d0);
    end
    tests++;
    if (last_done_cyc - prev_done_cyc !== 10) begin
      fails++;
      $display("FAIL b2b_period: got %0d cycles expected 10", last_done_cyc - prev_done_cyc);
    end
    tests++;
    if (beat_cnt - b0 !== 8) begin
      fails++;
      $display("FAIL b2b_beats: got %0d expected 8", beat_cnt - b0);
    end
    check_resident("b2b", 128);
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pe[r][c] = 8'hFF;
    test_reset();
    test_idle();
    test_basic();
    test_gapped();
    test_busy();
    test_reset_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws_weight_loader.md
Name: ws_weight_loader

Overview:
- Weight-side initiator for the weight-stationary systolic array; drives the top-edge weight-shift inputs and the shared mode line of a ROWS x COLS PE grid.
- Accepts one weight tile from the upstream weight buffer as ROWS row-beats over a valid/ready stream, stores it locally, then shifts it down every column in the order that leaves row r's weights resident in PE row r.
- Sole owner of the array mode signal. Asserts weight-load mode only during the shift window, and only while the array is not computing.

Parameters:
- WORDWIDTH, 8, bits per weight word (int8).
- ROWS, 4, PE rows per column, which is also the shift depth (>=2).
- COLS, 4, PE columns loaded in parallel (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- w_valid  in  1  upstream beat valid.
- w_ready  out  1  loader can accept a beat.
- w_data  in  COLS*WORDWIDTH  one tile row; column c at [c*WORDWIDTH +: WORDWIDTH].
- array_busy  in  1  compute controller has partial-sum work in flight; weight load is forbidden while high.
- mode_o  out  1  array mode: 1 = weight load (MODE_WL), 0 = partial-sum compute (MODE_PS).
- w_col  out  COLS*WORDWIDTH  weight words to the row-0 PE w_in of each column.
- load_done  out  1  one-cycle pulse when a tile is fully resident.
- weights_loaded  out  1  level; array holds a complete, valid tile.

Behaviour:
- Reset values (asynchronous, immediate): w_ready=0, mode_o=0, w_col=0, load_done=0, weights_loaded=0. State=IDLE, row counter=0, tile buffer=0.
- All outputs are registered except w_ready, which is decoded from state.
- FSM states: IDLE, FILL, ARB, SHIFT, DONE.
- Beat acceptance: a beat is accepted only on a cycle with w_valid and w_ready both high. w_valid may drop between beats; w_data is ignored when no beat is accepted.
- IDLE: w_ready=1. On an accepted beat, store it as row 0, set counter=1, go to FILL.
  - If ROWS beats are required and this is the only one, behaviour is covered by ROWS>=2.
- FILL: w_ready=1. Each accepted beat is stored as row[counter], then counter increments. The beat that lands at row ROWS-1 moves the FSM to ARB.
- ARB: w_ready=0. If array_busy=0 this cycle, go to SHIFT next cycle. Otherwise hold in ARB indefinitely.
- SHIFT: exactly ROWS consecutive cycles, k = 0..ROWS-1. On each cycle, mode_o=1 and w_col = buffer row ROWS-1-k.
  - weights_loaded clears in the first SHIFT cycle.
  - array_busy is ignored during SHIFT.
  - A PE row shifts on every mode=1 edge, so after ROWS edges PE row r holds buffer row r.
- DONE: a single cycle. mode_o=0, w_col=0, load_done=1, weights_loaded=1, w_ready=0. Next state is IDLE.
- Beats offered outside IDLE/FILL are stalled (w_ready=0). The loader never drops or overwrites a buffered tile.
- weights_loaded stays 1 through IDLE/FILL/ARB of the next tile. The resident tile is untouched until the next SHIFT begins.
- mode_o is never 1 outside SHIFT. In particular it is 0 in ARB while array_busy=1.
- Reset mid-operation (any state, including mid-SHIFT): returns to the reset values. weights_loaded=0 because the array contents are now partial. No load_done pulse is issued.
- Back-to-back tiles: the minimum tile period is ROWS (fill) + 1 (ARB) + ROWS (shift) + 1 (DONE) cycles. A new fill may start on the cycle after DONE.
- Widths: pure data movement, no arithmetic. The counter is clog2(ROWS) bits, or 1 bit when ROWS=2, and never wraps past ROWS-1.

Test Plan:
All scenarios use ROWS=4, COLS=4, WORDWIDTH=8 and a bench model of a 4-deep PE weight chain per column. Tile entry row r, col c = 16*r+c.
1. Basic load: four back-to-back valid beats, array_busy=0.
   - Expect: mode_o=1 for exactly 4 cycles; w_col = rows 3,2,1,0 in that order; load_done pulses once.
   - Expect: model PE row r col c = 16*r+c; weights_loaded=1.
2. Gapped upstream: w_valid toggles 1,0,1,0,... across the four beats.
   - Expect: the same resident tile as scenario 1; no extra beats consumed; the shift starts 2 cycles after the 4th acceptance.
3. Busy array: array_busy=1 for 10 cycles after the 4th beat.
   - Expect: mode_o stays 0 and w_ready=0 throughout.
   - Expect: the shift begins the cycle after array_busy falls; w_valid offered meanwhile is not accepted.
4. Reset during SHIFT: assert reset_n=0 on the 2nd SHIFT cycle.
   - Expect: mode_o, w_col, weights_loaded and load_done are all 0 immediately.
   - Expect: a subsequent full tile (values +64) loads correctly.
5. Back-to-back tiles: tile A then tile B (values +128) offered continuously.
   - Expect: weights_loaded stays 1 from A's DONE until B's first SHIFT cycle, then 0 until B's DONE.
   - Expect: final array holds B; exactly two load_done pulses.
6. Idle stability: no w_valid for 50 cycles after reset.
   - Expect: w_ready=1, mode_o=0, w_col=0, load_done never asserted.
